input_conditioner: RTL

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 86 ++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - per-channel synchronizer, debouncer and press/release pulse generator (optional auto-repeat: INPUT_CONDITIONER_REPEAT_EN)
module input_conditioner #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]    cnt    [WIDTH];
    logic [WIDTH-1:0] s;

    assign s = sync_q[SYNC_STAGES-1];

`ifdef INPUT_CONDITIONER_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);

    logic [RW-1:0]    rpt_cnt [WIDTH];
    logic [WIDTH-1:0] rpt_first;
`else
    wire unused_repeat_cfg = (REPEAT_DELAY + REPEAT_PERIOD) > 0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
            level         <= '0;
            press         <= '0;
            release_pulse <= '0;
`ifdef INPUT_CONDITIONER_REPEAT_EN
            for (int i = 0; i < WIDTH; i++) rpt_cnt[i] <= '0;
            rpt_first <= '0;
`endif
        end else begin
            sync_q[0] <= raw;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];

            for (int i = 0; i < WIDTH; i++) begin
                press[i]         <= 1'b0;
                release_pulse[i] <= 1'b0;
                if (s[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt[i]           <= '0;
                    level[i]         <= ~level[i];
                    press[i]         <= ~level[i];
                    release_pulse[i] <= level[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end

`ifdef INPUT_CONDITIONER_REPEAT_EN
                // Repeat timing restarts on every debounced edge; it only runs while the level is steadily high.
                if (s[i] != level[i] && cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    rpt_cnt[i]   <= '0;
                    rpt_first[i] <= ~level[i];
                end else if (level[i]) begin
                    if (rpt_cnt[i] == (rpt_first[i] ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1))) begin
                        rpt_cnt[i]   <= '0;
                        rpt_first[i] <= 1'b0;
                        press[i]     <= 1'b1;
                    end else begin
                        rpt_cnt[i] <= rpt_cnt[i] + RW'(1);
                    end
                end else begin
                    rpt_cnt[i]   <= '0;
                    rpt_first[i] <= 1'b0;
                end
`endif
            end
        end
    end

endmodule
